// File: rtl/spi_fsm.sv
// SPI memory-slave transaction controller: counts conditioned SCLK edges, decodes the
// address byte's R/W bit and issues single-cycle strobes to address latch, memory and shifter.
module spi_fsm #(
  parameter int unsigned WIDTH            = 8,
  parameter int unsigned READ_WAIT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             chipSelect,
  input  logic             sclkPosEdge,
  input  logic             sclkNegEdge,
  input  logic [WIDTH-1:0] shiftRegOut,
  output logic             addrWe,
  output logic             dmWe,
  output logic             srWe,
  output logic             misoBufe,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] CntLast  = CntW'(WIDTH - 1);
  localparam logic [2:0]      WaitLast = 3'(READ_WAIT_CYCLES - 1);

  typedef enum logic [3:0] {
    StIdle,
    StGetAddr,
    StGotAddr,
    StReadWait,
    StReadLoad,
    StReadShift,
    StWriteGet,
    StWriteStore,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      wait_q, wait_d;

  // Only the R/W flag of the address byte is inspected here.
  logic unused_sr;
  assign unused_sr = ^shiftRegOut[WIDTH-1:1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    case (state_q)
      StIdle: begin
        if (!chipSelect) state_d = StGetAddr;
      end
      StGetAddr: begin
        if (sclkPosEdge) begin
          if (cnt_q == CntLast) state_d = StGotAddr;
          else                  cnt_d   = cnt_q + CntW'(1);
        end
      end
      StGotAddr: begin
        state_d = shiftRegOut[0] ? StReadWait : StWriteGet;
      end
      StReadWait: begin
        if (wait_q == WaitLast) state_d = StReadLoad;
        else                    wait_d  = wait_q + 3'd1;
      end
      StReadLoad: begin
        state_d = StReadShift;
      end
      StReadShift: begin
        if (sclkNegEdge) begin
          if (cnt_q == CntLast) state_d = StDone;
          else                  cnt_d   = cnt_q + CntW'(1);
        end
      end
      StWriteGet: begin
        if (sclkPosEdge) begin
          if (cnt_q == CntLast) state_d = StWriteStore;
          else                  cnt_d   = cnt_q + CntW'(1);
        end
      end
      StWriteStore: begin
        state_d = StDone;
      end
      StDone: begin
        state_d = StDone;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // CS deassertion aborts from anywhere, ahead of every other transition.
    if (state_q != StIdle && chipSelect) state_d = StIdle;

    if (state_d != state_q) begin
      cnt_d  = '0;
      wait_d = '0;
    end
  end

  // Outputs are registered alongside the state so they decode the state held this cycle.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      wait_q   <= '0;
      addrWe   <= 1'b0;
      dmWe     <= 1'b0;
      srWe     <= 1'b0;
      misoBufe <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wait_q   <= wait_d;
      addrWe   <= (state_d == StGotAddr);
      dmWe     <= (state_d == StWriteStore);
      srWe     <= (state_d == StReadLoad);
      misoBufe <= (state_d == StReadShift);
      busy     <= (state_d != StIdle);
    end
  end

endmodule
